fwd_network: RTL and testbench
==============================

// Module: fwd_network
// PURPOSE
//  Parametrised forwarding and hazard network for the segmented LagartoII core; generalises the fixed 3-way operand mux.
//  - Tracks destination registers of in-flight instructions in an internal shift pipeline.
//  - For NSRC decode operands, selects the youngest matching in-flight result, else register-file data.
//  - Raises a load-use stall and injects a bubble when a needed load result is not yet available.
// PARAMETERS
//  DATA_W     32  operand/result width
//  REG_AW     5   register address width; register 0 is hardwired zero
//  DEPTH      3   tracked stages after decode (entry 0 = EX, 1 = MEM, 2 = WB)
//  NSRC       2   source operands resolved per cycle
//  LOAD_STAGE 1   first entry index at which load data is valid on stage_data_i
// PORTS
//  clk_i          in   1              clock, rising edge
//  rst_i          in   1              asynchronous, active-high reset
//  issue_valid_i  in   1              instruction leaves decode into EX this cycle
//  issue_rd_i     in   REG_AW         its destination register
//  issue_we_i     in   1              it writes issue_rd_i
//  issue_load_i   in   1              it is a load
//  flush_i        in   1              kill the instruction entering EX
//  stage_data_i   in   DEPTH*DATA_W   result currently held in entry k, slice [k*DATA_W +: DATA_W]
//  src_used_i     in   NSRC           operand i is actually read
//  src_addr_i     in   NSRC*REG_AW    operand register addresses
//  src_data_i     in   NSRC*DATA_W    register-file read data
//  fwd_data_o     out  NSRC*DATA_W    resolved operand data
//  fwd_sel_o      out  NSRC*SW        0 = register file, k+1 = entry k; SW = $clog2(DEPTH+1)
//  stall_o        out  1              load-use stall; decode holds, bubble enters EX
// BEHAVIOUR
//  - Entry state per stage: valid, rd, we, load. Reset clears every valid bit. Outputs out of reset:
//    fwd_data_o = src_data_i, fwd_sel_o = 0, stall_o = 0.
//  - Shift on every clock edge: entry[k] <= entry[k-1] for k >= 1. The pipeline never freezes downstream of decode.
//  - Entry 0 next value, in priority order:
//    - flush_i = 1 -> invalid.
//    - stall_o = 1 -> invalid (bubble); issue_valid_i is ignored.
//    - otherwise -> {issue_valid_i, issue_rd_i, issue_we_i, issue_load_i}.
//  - Match for operand i on entry k: valid & we & (rd == src_addr_i[i]) & (src_addr_i[i] != 0) & src_used_i[i].
//  - Selection: the lowest k that matches (youngest) wins.
//    - fwd_sel_o[i] = k+1 and fwd_data_o[i] = stage_data_i slice k.
//    - With no match: fwd_sel_o[i] = 0 and fwd_data_o[i] = src_data_i[i].
//  - Load-use: if the winning entry for any operand has load = 1 and k < LOAD_STAGE, stall_o = 1.
//    - That operand's fwd_sel_o = 0; its data is don't-care.
//    - Older matching entries are never used in place of the winner.
//  - Forwarding and stall are purely combinational from current entry state and inputs, with zero latency.
//    State updates take one cycle.
//  - A stall lasts until the load reaches LOAD_STAGE, i.e. LOAD_STAGE cycles with the defaults.
//    No FSM is needed beyond the shift.
//  - flush_i and stall_o together: flush wins, and entry 0 goes invalid either way.
//  - rst_i mid-stall: entries clear immediately and stall_o drops asynchronously.
//  - Entries with we = 0, or rd = 0, never forward and never stall.
// CONFIGURATION
//  FWD_PERF_CNT_EN defined:
//    - Adds output stall_cnt_o [31:0], incremented on each clock with stall_o = 1.
//    - Saturates at 32'hFFFF_FFFF; cleared to 0 by rst_i.
//  FWD_PERF_CNT_EN undefined:
//    - Port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset, no issues, src_addr = {5,6}, src_data = {A,B} -> fwd_data = {A,B}, fwd_sel = {0,0}, stall_o = 0.
//  2. Issue ALU rd = 5 we = 1, next cycle src0 = 5, stage_data[0] = 32'h1234 -> fwd_sel0 = 1, fwd_data0 = 32'h1234.
//     One cycle later, with stage_data[1] = 32'h1234: fwd_sel0 = 2.
//  3. Issue rd = 7 twice back-to-back with different data, then read src1 = 7 -> fwd_sel1 = 1 (youngest wins),
//     not 2.
//  4. Issue load rd = 9, next cycle src0 = 9 used -> stall_o = 1 for exactly 1 cycle and entry 0 is a bubble.
//     Following cycle: fwd_sel0 = 2, data from stage_data[1]. Repeat with src_used_i = 0 -> no stall.
//  5. src_addr = 0 with entry 0 rd = 0 we = 1 -> fwd_sel = 0, no stall.
//     Issue with we = 0 rd = 3, read src = 3 -> fwd_sel = 0.
//  6. Load rd = 4 issued with flush_i = 1 -> entry 0 invalid, reading 4 next cycle gives no stall.
//     Assert rst_i during a stall -> stall_o = 0 immediately. With FWD_PERF_CNT_EN, test 4 leaves stall_cnt_o = 1.

Source files
------------

// File: rtl/fwd_network_if.sv
// Decode-side bundle for the forwarding network: issue info, operand requests, stage results and resolved operands.
// stall_cnt_o is present only when FWD_PERF_CNT_EN is defined.
interface fwd_network_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 3,
   parameter int NSRC   = 2,
   parameter int SW     = $clog2(DEPTH+1)
);
   logic                     issue_valid_i;
   logic [REG_AW-1:0]        issue_rd_i;
   logic                     issue_we_i;
   logic                     issue_load_i;
   logic                     flush_i;
   logic [DEPTH*DATA_W-1:0]  stage_data_i;
   logic [NSRC-1:0]          src_used_i;
   logic [NSRC*REG_AW-1:0]   src_addr_i;
   logic [NSRC*DATA_W-1:0]   src_data_i;
   logic [NSRC*DATA_W-1:0]   fwd_data_o;
   logic [NSRC*SW-1:0]       fwd_sel_o;
   logic                     stall_o;
`ifdef FWD_PERF_CNT_EN
   logic [31:0]              stall_cnt_o;
`endif

   modport master (
      output issue_valid_i, issue_rd_i, issue_we_i, issue_load_i, flush_i,
      output stage_data_i, src_used_i, src_addr_i, src_data_i,
`ifdef FWD_PERF_CNT_EN
      input  stall_cnt_o,
`endif
      input  fwd_data_o, fwd_sel_o, stall_o
   );

   modport slave (
      input  issue_valid_i, issue_rd_i, issue_we_i, issue_load_i, flush_i,
      input  stage_data_i, src_used_i, src_addr_i, src_data_i,
`ifdef FWD_PERF_CNT_EN
      output stall_cnt_o,
`endif
      output fwd_data_o, fwd_sel_o, stall_o
   );
endinterface

// File: rtl/fwd_network.sv
// Operand forwarding + load-use hazard network: zero-latency combinational select, one-cycle entry shift.
// Stall holds decode and injects a bubble into EX; FWD_PERF_CNT_EN adds a saturating stall counter.
module fwd_network #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 3,
   parameter int NSRC       = 2,
   parameter int LOAD_STAGE = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   fwd_network_if.slave bus
);
   localparam int SW = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  entValid;
   logic [DEPTH-1:0]  entWe;
   logic [DEPTH-1:0]  entLoad;
   logic [REG_AW-1:0] entRd [DEPTH];

   logic [NSRC-1:0]        opStall;
   logic [NSRC*DATA_W-1:0] fwdData;
   logic [NSRC*SW-1:0]     fwdSel;
   logic                   stall;

   // Downstream stages always advance; only the EX entry can be killed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         entValid <= '0;
         entWe    <= '0;
         entLoad  <= '0;
         for (int k = 0; k < DEPTH; k++) entRd[k] <= '0;
      end else begin
         for (int k = 1; k < DEPTH; k++) begin
            entValid[k] <= entValid[k-1];
            entWe[k]    <= entWe[k-1];
            entLoad[k]  <= entLoad[k-1];
            entRd[k]    <= entRd[k-1];
         end
         entValid[0] <= bus.issue_valid_i & ~bus.flush_i & ~stall;
         entWe[0]    <= bus.issue_we_i;
         entLoad[0]  <= bus.issue_load_i;
         entRd[0]    <= bus.issue_rd_i;
      end
   end

   always_comb begin
      opStall = '0;
      fwdData = bus.src_data_i;
      fwdSel  = '0;
      for (int i = 0; i < NSRC; i++) begin
         logic              found;
         logic [REG_AW-1:0] addr;
         found = 1'b0;
         addr  = bus.src_addr_i[i*REG_AW +: REG_AW];
         // First hit scanning from EX is the youngest producer; older ones are never considered.
         for (int k = 0; k < DEPTH; k++) begin
            if (!found && entValid[k] && entWe[k] && (entRd[k] == addr) &&
                (addr != '0) && bus.src_used_i[i]) begin
               found = 1'b1;
               if (entLoad[k] && (k < LOAD_STAGE)) begin
                  opStall[i] = 1'b1;
               end else begin
                  fwdSel[i*SW +: SW]      = SW'(k + 1);
                  fwdData[i*DATA_W +: DATA_W] = bus.stage_data_i[k*DATA_W +: DATA_W];
               end
            end
         end
      end
      stall = |opStall;
   end

   assign bus.fwd_data_o = fwdData;
   assign bus.fwd_sel_o  = fwdSel;
   assign bus.stall_o    = stall;

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stallCnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stallCnt <= '0;
      end else if (stall && (stallCnt != 32'hFFFF_FFFF)) begin
         stallCnt <= stallCnt + 32'd1;
      end
   end

   assign bus.stall_cnt_o = stallCnt;
`endif
endmodule

// File: tb/tb_fwd_network.sv
// Directed and random checks of fwd_network against a history-list model of in-flight instructions.
module tb_fwd_network;
   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int DEPTH  = 3;
   localparam int NSRC   = 2;
   localparam int LOAD_STAGE = 1;
   localparam int SW = $clog2(DEPTH+1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fwd_network_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .NSRC(NSRC)) bus ();

   fwd_network #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .NSRC(NSRC),
                 .LOAD_STAGE(LOAD_STAGE)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   // Model: what entered EX on each of the last DEPTH cycles, youngest first.
   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       we;
      bit       ld;
   } instr_t;
   instr_t hist [DEPTH];

   int total = 0;
   int bad   = 0;
   int unsigned modelCnt = 0;
   bit [SW-1:0]     expSel   [NSRC];
   bit [DATA_W-1:0] expData  [NSRC];
   bit              expOpStall [NSRC];
   bit              expStall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < DEPTH; k++) hist[k] = '{v: 0, rd: 0, we: 0, ld: 0};
      modelCnt = 0;
   endtask

   task automatic model_eval();
      expStall = 0;
      for (int i = 0; i < NSRC; i++) begin
         bit [4:0] a;
         bit hit;
         a = bus.src_addr_i[i*REG_AW +: REG_AW];
         hit = 0;
         expSel[i] = 0;
         expOpStall[i] = 0;
         expData[i] = bus.src_data_i[i*DATA_W +: DATA_W];
         if (bus.src_used_i[i] && a != 0) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (!hit && hist[k].v && hist[k].we && hist[k].rd == a) begin
                  hit = 1;
                  if (hist[k].ld && k < LOAD_STAGE) expOpStall[i] = 1;
                  else begin
                     expSel[i]  = SW'(k + 1);
                     expData[i] = bus.stage_data_i[k*DATA_W +: DATA_W];
                  end
               end
            end
         end
         if (expOpStall[i]) expStall = 1;
      end
   endtask

   task automatic settle_check(input string tag);
      #2;
      model_eval();
      chk({tag, ".stall"}, {63'd0, bus.stall_o}, {63'd0, expStall});
      for (int i = 0; i < NSRC; i++) begin
         chk($sformatf("%s.sel%0d", tag, i), 64'(bus.fwd_sel_o[i*SW +: SW]), 64'(expSel[i]));
         if (!expOpStall[i])
            chk($sformatf("%s.data%0d", tag, i), 64'(bus.fwd_data_o[i*DATA_W +: DATA_W]), 64'(expData[i]));
      end
`ifdef FWD_PERF_CNT_EN
      chk({tag, ".cnt"}, 64'(bus.stall_cnt_o), 64'(modelCnt));
`endif
   endtask

   task automatic advance();
      model_eval();
      if (!rst) begin
         if (expStall && modelCnt != 32'hFFFF_FFFF) modelCnt++;
         for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0].v  = bus.issue_valid_i && !bus.flush_i && !expStall;
         hist[0].rd = bus.issue_rd_i;
         hist[0].we = bus.issue_we_i;
         hist[0].ld = bus.issue_load_i;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit v, input bit [4:0] rd, input bit we, input bit ld, input bit fl);
      bus.issue_valid_i = v;
      bus.issue_rd_i    = rd;
      bus.issue_we_i    = we;
      bus.issue_load_i  = ld;
      bus.flush_i       = fl;
   endtask

   task automatic src(input int i, input bit [4:0] a, input bit used);
      bus.src_addr_i[i*REG_AW +: REG_AW] = a;
      bus.src_used_i[i] = used;
   endtask

   initial begin
      logic [DEPTH*DATA_W-1:0] sd;
      model_clear();
      issue(0, 0, 0, 0, 0);
      bus.stage_data_i = '0;
      src(0, 5, 1);
      src(1, 6, 1);
      bus.src_data_i = {32'hBBBB_0002, 32'hAAAA_0001};

      // 1: reset state
      settle_check("rst");
      chk("rst.data", 64'(bus.fwd_data_o), 64'({32'hBBBB_0002, 32'hAAAA_0001}));
      chk("rst.sel", 64'(bus.fwd_sel_o), 64'd0);
      advance();
      rst = 1'b0;

      // 2: ALU result forwarded from EX, then from MEM
      src(0, 5, 0); src(1, 6, 0);
      issue(1, 5, 1, 0, 0);
      settle_check("t2a");
      advance();
      issue(0, 0, 0, 0, 0);
      src(0, 5, 1);
      sd = '0; sd[31:0] = 32'h1234; bus.stage_data_i = sd;
      settle_check("t2b");
      chk("t2.sel_ex", 64'(bus.fwd_sel_o[SW-1:0]), 64'd1);
      chk("t2.data_ex", 64'(bus.fwd_data_o[31:0]), 64'h1234);
      advance();
      sd = '0; sd[63:32] = 32'h1234; bus.stage_data_i = sd;
      settle_check("t2c");
      chk("t2.sel_mem", 64'(bus.fwd_sel_o[SW-1:0]), 64'd2);

      // 3: youngest of two writers to r7 wins
      src(0, 0, 0);
      issue(1, 7, 1, 0, 0); advance();
      issue(1, 7, 1, 0, 0); advance();
      issue(0, 0, 0, 0, 0);
      bus.stage_data_i = {32'h3333, 32'h2222, 32'h1111};
      src(1, 7, 1);
      settle_check("t3");
      chk("t3.sel_young", 64'(bus.fwd_sel_o[SW +: SW]), 64'd1);
      chk("t3.data_young", 64'(bus.fwd_data_o[DATA_W +: DATA_W]), 64'h1111);
      src(1, 0, 0);

      // 4: load-use stall, one cycle, with issue ignored during the bubble
      issue(1, 9, 1, 1, 0); advance();
      issue(1, 9, 1, 1, 0);
      src(0, 9, 1);
      settle_check("t4a");
      chk("t4.stall", 64'(bus.stall_o), 64'd1);
      chk("t4.sel_stall", 64'(bus.fwd_sel_o[SW-1:0]), 64'd0);
      advance();
      issue(0, 0, 0, 0, 0);
      bus.stage_data_i = {32'hC0C0, 32'hB0B0, 32'hA0A0};
      settle_check("t4b");
      chk("t4.no_stall", 64'(bus.stall_o), 64'd0);
      chk("t4.sel_mem", 64'(bus.fwd_sel_o[SW-1:0]), 64'd2);
      chk("t4.data_mem", 64'(bus.fwd_data_o[31:0]), 64'hB0B0);
`ifdef FWD_PERF_CNT_EN
      chk("t4.cnt", 64'(bus.stall_cnt_o), 64'd1);
`endif
      src(0, 0, 0);
      issue(1, 9, 1, 1, 0); advance();
      issue(0, 0, 0, 0, 0);
      src(0, 9, 0);
      settle_check("t4c");
      chk("t4.unused", 64'(bus.stall_o), 64'd0);

      // 5: r0 and non-writing producers never forward
      issue(1, 0, 1, 0, 0); advance();
      issue(0, 0, 0, 0, 0);
      src(0, 0, 1);
      settle_check("t5a");
      chk("t5.r0", 64'(bus.fwd_sel_o[SW-1:0]), 64'd0);
      issue(1, 3, 0, 1, 0); advance();
      issue(0, 0, 0, 0, 0);
      src(0, 3, 1);
      settle_check("t5b");
      chk("t5.we0", 64'(bus.fwd_sel_o[SW-1:0]), 64'd0);

      // 6: flushed load never stalls; reset drops an active stall at once
      src(0, 0, 0);
      issue(1, 4, 1, 1, 1); advance();
      issue(0, 0, 0, 0, 0);
      src(0, 4, 1);
      settle_check("t6a");
      chk("t6.flush", 64'(bus.stall_o), 64'd0);
      src(0, 0, 0);
      issue(1, 4, 1, 1, 0); advance();
      issue(0, 0, 0, 0, 0);
      src(0, 4, 1);
      settle_check("t6b");
      chk("t6.pre_rst", 64'(bus.stall_o), 64'd1);
      rst = 1'b1;
      #1;
      model_clear();
      chk("t6.rst_stall", 64'(bus.stall_o), 64'd0);
`ifdef FWD_PERF_CNT_EN
      chk("t6.rst_cnt", 64'(bus.stall_cnt_o), 64'd0);
`endif
      advance();
      rst = 1'b0;

      // Random traffic over a small register window to provoke frequent hazards
      for (int n = 0; n < 400; n++) begin
         issue($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
         for (int i = 0; i < NSRC; i++) src(i, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
         bus.stage_data_i = {$urandom(), $urandom(), $urandom()};
         bus.src_data_i   = {$urandom(), $urandom()};
         settle_check("rnd");
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
